// File: rtl/avg_pkg.sv
`default_nettype none
// ============================================================================
// Package  : avg_pkg
// Brief    : Shared sizing helpers and stage side-band record for avg_tree_pipe.
// Revision : 1.0 - initial release
// ============================================================================
package avg_pkg;

    // Wide enough for any clamped shift amount (SUMW <= 255).
    localparam int SA_MAX_W = 8;

    // Side-band travelling with each pipeline stage; the sum itself rides on a
    // separate bus because its width grows by one bit per tree level.
    typedef struct packed {
        logic                valid;
        logic                rnd;
        logic [SA_MAX_W-1:0] sa_eff;
    } side_t;

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

    function automatic int sum_w(input int width, input int n);
        return width + clog2(n);
    endfunction

    // Bit offset of tree level 'level' inside the packed tree bus.
    function automatic int tree_off(input int width, input int n, input int level);
        int off;
        off = 0;
        for (int k = 0; k < level; k++) begin
            off = off + (n >> k) * (width + k);
        end
        return off;
    endfunction

endpackage
`default_nettype wire

// File: rtl/avg_add_stage.sv
`default_nettype none
// ============================================================================
// Module   : avg_add_stage
// Brief    : One registered adder-tree level: IN_CNT operands -> IN_CNT/2 sums.
// Revision : 1.0 - initial release
// ============================================================================
module avg_add_stage
    import avg_pkg::*;
#(
    parameter int IN_CNT = 2,
    parameter int IN_W   = 16
)
(
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               i_hold,
    input  side_t                              i_side,
    input  logic [IN_CNT*IN_W-1:0]             i_data,
    output side_t                              o_side,
    output logic [(IN_CNT/2)*(IN_W+1)-1:0]     o_data
);

    localparam int c_OUT_CNT = IN_CNT / 2;
    localparam int c_OUT_W   = IN_W + 1;

    logic [c_OUT_CNT*c_OUT_W-1:0] w_sum;
    logic [c_OUT_CNT*c_OUT_W-1:0] r_sum;
    side_t                        r_side;

    for (genvar p = 0; p < c_OUT_CNT; p++) begin : g_pair
        assign w_sum[p*c_OUT_W +: c_OUT_W] = {1'b0, i_data[(2*p)*IN_W   +: IN_W]}
                                           + {1'b0, i_data[(2*p+1)*IN_W +: IN_W]};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_side <= '0;
            r_sum  <= '0;
        end else if (!i_hold) begin
            r_side <= i_side;
            r_sum  <= w_sum;
        end
    end

    assign o_side = r_side;
    assign o_data = r_sum;

endmodule
`default_nettype wire

// File: rtl/avg_tree_pipe.sv
`default_nettype none
// ============================================================================
// Module   : avg_tree_pipe
// Brief    : Pipelined N-channel averager: adder tree, round/shift, saturate,
//            with valid/ready flow control at full throughput.
// Revision : 1.0 - initial release
// ============================================================================
module avg_tree_pipe
    import avg_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int N     = 8,
    parameter int SAW   = 5
)
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [N*WIDTH-1:0]   in_data,
    input  logic [SAW-1:0]       sa,
    input  logic                 rnd,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     avg,
    output logic                 sat
);

    localparam int c_LOG2N     = clog2(N);
    localparam int c_SUMW      = sum_w(WIDTH, N);
    localparam int c_EXT_W     = c_SUMW + 1;
    localparam int c_TREE_W    = tree_off(WIDTH, N, c_LOG2N + 1);
    localparam int c_FINAL_OFF = tree_off(WIDTH, N, c_LOG2N);

    logic [c_TREE_W-1:0]  w_tree;
    side_t                w_side [0:c_LOG2N];
    logic                 w_stall;
    logic [SA_MAX_W-1:0]  w_sa_eff;
    logic [c_SUMW-1:0]    w_sum;
    logic [c_EXT_W-1:0]   w_round;
    logic [c_EXT_W-1:0]   w_q;
    logic                 w_sat_next;
    logic [WIDTH-1:0]     w_avg_next;

    logic                 r_out_valid;
    logic [WIDTH-1:0]     r_avg;
    logic                 r_sat;

    // A full output register that is not being taken freezes the whole pipe.
    assign w_stall  = r_out_valid && !out_ready;
    assign in_ready = !w_stall;

    always_comb begin
        w_sa_eff = SA_MAX_W'(c_SUMW);
        if (32'(sa) < 32'(c_SUMW)) begin
            w_sa_eff = SA_MAX_W'(sa);
        end
    end

    assign w_side[0]             = '{valid: in_valid, rnd: rnd, sa_eff: w_sa_eff};
    assign w_tree[0 +: N*WIDTH]  = in_data;

    for (genvar j = 0; j < c_LOG2N; j++) begin : g_stage
        localparam int c_IN_CNT  = N >> j;
        localparam int c_IN_W    = WIDTH + j;
        localparam int c_IN_OFF  = tree_off(WIDTH, N, j);
        localparam int c_OUT_OFF = tree_off(WIDTH, N, j + 1);

        avg_add_stage #(
            .IN_CNT (c_IN_CNT),
            .IN_W   (c_IN_W)
        ) u_stage (
            .clk    (clk),
            .rst    (rst),
            .i_hold (w_stall),
            .i_side (w_side[j]),
            .i_data (w_tree[c_IN_OFF +: c_IN_CNT*c_IN_W]),
            .o_side (w_side[j+1]),
            .o_data (w_tree[c_OUT_OFF +: (c_IN_CNT/2)*(c_IN_W+1)])
        );
    end

    assign w_sum = w_tree[c_FINAL_OFF +: c_SUMW];

    // One spare bit keeps sum + half-LSB rounding free of overflow.
    always_comb begin
        w_round = '0;
        if (w_side[c_LOG2N].rnd && (w_side[c_LOG2N].sa_eff != '0)) begin
            w_round = c_EXT_W'(1) << (w_side[c_LOG2N].sa_eff - SA_MAX_W'(1));
        end
        w_q        = ({1'b0, w_sum} + w_round) >> w_side[c_LOG2N].sa_eff;
        w_sat_next = |w_q[c_SUMW:WIDTH];
        w_avg_next = w_sat_next ? {WIDTH{1'b1}} : w_q[WIDTH-1:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_out_valid <= 1'b0;
            r_avg       <= '0;
            r_sat       <= 1'b0;
        end else if (!w_stall) begin
            r_out_valid <= w_side[c_LOG2N].valid;
            r_avg       <= w_avg_next;
            r_sat       <= w_sat_next;
        end
    end

    assign out_valid = r_out_valid;
    assign avg       = r_avg;
    assign sat       = r_sat;

endmodule
`default_nettype wire

// File: tb/tb_avg_tree_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_avg_tree_pipe
// Brief    : Directed self-checking bench for avg_tree_pipe (8x16 and 2x8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_avg_tree_pipe;

    logic         clk = 1'b0;
    logic         rst;

    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic [4:0]   sa;
    logic         rnd;
    logic         out_valid;
    logic         out_ready;
    logic [15:0]  avg;
    logic         sat;

    logic         s_in_valid;
    logic         s_in_ready;
    logic [15:0]  s_in_data;
    logic [4:0]   s_sa;
    logic         s_rnd;
    logic         s_out_valid;
    logic         s_out_ready;
    logic [7:0]   s_avg;
    logic         s_sat;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    avg_tree_pipe #(.WIDTH(16), .N(8), .SAW(5)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .sa        (sa),
        .rnd       (rnd),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .avg       (avg),
        .sat       (sat)
    );

    avg_tree_pipe #(.WIDTH(8), .N(2), .SAW(5)) u_small (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (s_in_valid),
        .in_ready  (s_in_ready),
        .in_data   (s_in_data),
        .sa        (s_sa),
        .rnd       (s_rnd),
        .out_valid (s_out_valid),
        .out_ready (s_out_ready),
        .avg       (s_avg),
        .sat       (s_sat)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Reference: floor((sum + r) / 2^sa_eff), clipped to 16 bits.
    function automatic logic [16:0] model(input logic [127:0] d, input logic [4:0] s, input logic r);
        longint sum;
        longint rr;
        longint q;
        int     se;
        sum = 0;
        for (int k = 0; k < 8; k++) sum += longint'(d[k*16 +: 16]);
        se = (s > 5'd19) ? 19 : int'(s);
        rr = (r && se > 0) ? (longint'(1) << (se - 1)) : 0;
        q  = (sum + rr) >> se;
        if (q > 65535) return {1'b1, 16'hFFFF};
        return {1'b0, 16'(q)};
    endfunction

    initial begin
        #400000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [127:0] v_data [20];
        logic [4:0]   v_sa   [20];
        logic         v_rnd  [20];
        logic [16:0]  exp_q  [$];
        logic [16:0]  e;
        logic [127:0] d2 [4];
        logic [4:0]   sa2 [4];
        logic         rnd2 [4];
        logic [15:0]  ea2 [4];
        logic         es2 [4];
        int           got;
        int           sent;
        int           recvd;
        int           cyc;
        logic         prev_stall;
        logic [15:0]  held_avg;
        logic         held_sat;

        rst = 1'b0;
        in_valid = 1'b0; in_data = '0; sa = '0; rnd = 1'b0; out_ready = 1'b1;
        s_in_valid = 1'b0; s_in_data = '0; s_sa = '0; s_rnd = 1'b0; s_out_ready = 1'b1;
        repeat (3) @(negedge clk);

        // Reset state
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_avg", 32'(avg), 32'd0);
        check("reset_sat", 32'(sat), 32'd0);
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_small_out_valid", 32'(s_out_valid), 32'd0);

        // Test 1: sum 44, sa=3, rnd 0 then 1; latency 4
        rst = 1'b1;
        in_valid = 1'b1;
        in_data  = {16'd7, 16'd7, 16'd6, 16'd6, 16'd6, 16'd5, 16'd3, 16'd4};
        sa = 5'd3; rnd = 1'b0;
        #1;
        check("t1_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rnd = 1'b1;
        check("t1_lat1", 32'(out_valid), 32'd0);
        @(negedge clk);
        in_valid = 1'b0;
        check("t1_lat2", 32'(out_valid), 32'd0);
        @(negedge clk);
        check("t1_lat3", 32'(out_valid), 32'd0);
        @(negedge clk);
        check("t1_lat4_valid", 32'(out_valid), 32'd1);
        check("t1_avg_trunc", 32'(avg), 32'd5);
        check("t1_sat_trunc", 32'(sat), 32'd0);
        @(negedge clk);
        check("t1_valid_rnd", 32'(out_valid), 32'd1);
        check("t1_avg_rnd", 32'(avg), 32'd6);
        @(negedge clk);
        check("t1_drain", 32'(out_valid), 32'd0);

        // Tests 2 and 3: all-ones saturation and shift clamp
        d2[0] = {8{16'hFFFF}}; sa2[0] = 5'd0;  rnd2[0] = 1'b0; ea2[0] = 16'hFFFF; es2[0] = 1'b1;
        d2[1] = {8{16'hFFFF}}; sa2[1] = 5'd3;  rnd2[1] = 1'b0; ea2[1] = 16'hFFFF; es2[1] = 1'b0;
        d2[2] = {8{16'hFFFF}}; sa2[2] = 5'd31; rnd2[2] = 1'b1; ea2[2] = 16'd1;    es2[2] = 1'b0;
        d2[3] = {8{16'hFFFF}}; sa2[3] = 5'd31; rnd2[3] = 1'b0; ea2[3] = 16'd0;    es2[3] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_data = d2[i]; sa = sa2[i]; rnd = rnd2[i];
            @(negedge clk);
        end
        in_valid = 1'b0;
        got = 0;
        for (int c = 0; c < 20 && got < 4; c++) begin
            if (out_valid) begin
                check($sformatf("t23_avg_%0d", got), 32'(avg), 32'(ea2[got]));
                check($sformatf("t23_sat_%0d", got), 32'(sat), 32'(es2[got]));
                got++;
            end
            @(negedge clk);
        end
        check("t23_count", 32'(got), 32'd4);

        // Test 4: random stream with out_ready toggling every cycle
        for (int i = 0; i < 20; i++) begin
            for (int k = 0; k < 8; k++) v_data[i][k*16 +: 16] = 16'($urandom_range(0, 65535));
            if (i % 5 == 0) v_data[i] = {8{16'hFFFF}};
            v_sa[i]  = 5'($urandom_range(0, 31));
            v_rnd[i] = 1'($urandom_range(0, 1));
        end
        sent = 0; recvd = 0; cyc = 0; prev_stall = 1'b0; held_avg = '0; held_sat = 1'b0;
        while (recvd < 20 && cyc < 300) begin
            if (prev_stall) begin
                check("t4_hold_valid", 32'(out_valid), 32'd1);
                check("t4_hold_avg", 32'(avg), 32'(held_avg));
                check("t4_hold_sat", 32'(sat), 32'(held_sat));
            end
            out_ready = (cyc % 2 == 0);
            if (sent < 20) begin
                in_valid = 1'b1; in_data = v_data[sent]; sa = v_sa[sent]; rnd = v_rnd[sent];
            end else begin
                in_valid = 1'b0;
            end
            #1;
            check("t4_in_ready", 32'(in_ready), 32'(!(out_valid && !out_ready)));
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("t4_unexpected_out", 32'(out_valid), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check($sformatf("t4_avg_%0d", recvd), 32'(avg), 32'(e[15:0]));
                    check($sformatf("t4_sat_%0d", recvd), 32'(sat), 32'(e[16]));
                    recvd++;
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model(in_data, sa, rnd));
                sent++;
            end
            prev_stall = out_valid && !out_ready;
            held_avg   = avg;
            held_sat   = sat;
            cyc++;
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("t4_received", 32'(recvd), 32'd20);
        check("t4_leftover", 32'(exp_q.size()), 32'd0);
        got = 0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid) got++;
        end
        check("t4_no_duplicates", 32'(got), 32'd0);

        // Test 5: asynchronous reset with vectors in flight
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_data = {8{16'(i + 1)}}; sa = 5'd0; rnd = 1'b0;
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("t5_pre_reset_valid", 32'(out_valid), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check("t5_async_drop", 32'(out_valid), 32'd0);
        check("t5_reset_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        check("t5_held_in_reset", 32'(out_valid), 32'd0);
        rst = 1'b1;
        in_valid = 1'b1; in_data = {8{16'd8}}; sa = 5'd3; rnd = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        check("t5_no_stale_1", 32'(out_valid), 32'd0);
        @(negedge clk);
        check("t5_no_stale_2", 32'(out_valid), 32'd0);
        @(negedge clk);
        check("t5_no_stale_3", 32'(out_valid), 32'd0);
        @(negedge clk);
        check("t5_first_valid", 32'(out_valid), 32'd1);
        check("t5_first_avg", 32'(avg), 32'd8);
        @(negedge clk);

        // Test 6: N=2, WIDTH=8 instance
        s_in_valid = 1'b1; s_in_data = {8'd100, 8'd200}; s_sa = 5'd1; s_rnd = 1'b0;
        @(negedge clk);
        s_in_data = {8'd255, 8'd255}; s_sa = 5'd0;
        check("t6_lat1", 32'(s_out_valid), 32'd0);
        @(negedge clk);
        s_in_valid = 1'b0;
        check("t6_lat2_valid", 32'(s_out_valid), 32'd1);
        check("t6_avg_150", 32'(s_avg), 32'd150);
        check("t6_sat_0", 32'(s_sat), 32'd0);
        @(negedge clk);
        check("t6_valid_2", 32'(s_out_valid), 32'd1);
        check("t6_avg_255", 32'(s_avg), 32'd255);
        check("t6_sat_1", 32'(s_sat), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
